// File: rtl/frame_align_pkg.sv
// Shared constants and types for the serial frame aligner.
// Contents: FSM state encodings, byte/bit widths, default sync pattern
// and frame length, and the packed record held in the output register.
package frame_align_pkg;

  localparam int unsigned BITS_PER_BYTE     = 8;
  localparam int unsigned BIT_CNT_W         = 3;
  localparam int unsigned BYTE_IDX_W        = 4;
  localparam int unsigned DEFAULT_FRAME_LEN = 4;
  localparam logic [BITS_PER_BYTE-1:0] DEFAULT_SYNC_BYTE = 8'hA5;

  localparam logic [0:0] ST_HUNT   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  // One emitted payload byte plus its strobes.
  typedef struct packed {
    logic [BITS_PER_BYTE-1:0] data;
    logic [BYTE_IDX_W-1:0]    idx;
    logic                     valid;
    logic                     done;
  } byte_beat_t;

endpackage

// File: rtl/frame_byte_counter.sv
// Bit and byte position counters for a locked frame.
// Ports:
//   Clk, Reset   clock and synchronous active-high reset
//   clr_i        zero both counters (has priority over en_i)
//   en_i         advance the bit counter; on a byte boundary advance the
//                byte counter, wrapping to 0 after the last byte
//   byte_cnt_o   index of the byte currently being assembled
//   byte_tick_o  bit counter is at 7: this edge completes a byte
//   last_byte_o  byte counter is at FRAME_LEN-1
module frame_byte_counter
  import frame_align_pkg::*;
#(
  parameter int unsigned FRAME_LEN = DEFAULT_FRAME_LEN
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  clr_i,
  input  logic                  en_i,
  output logic [BYTE_IDX_W-1:0] byte_cnt_o,
  output logic                  byte_tick_o,
  output logic                  last_byte_o
);

  logic [BIT_CNT_W-1:0]  bit_cnt_q,  bit_cnt_d;
  logic [BYTE_IDX_W-1:0] byte_cnt_q, byte_cnt_d;

  assign byte_tick_o = (bit_cnt_q == BIT_CNT_W'(BITS_PER_BYTE - 1));
  assign last_byte_o = (byte_cnt_q == BYTE_IDX_W'(FRAME_LEN - 1));
  assign byte_cnt_o  = byte_cnt_q;

  // Next-state: bit counter wraps 7->0 naturally; byte counter wraps at frame end.
  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    if (clr_i) begin
      bit_cnt_d  = '0;
      byte_cnt_d = '0;
    end else if (en_i) begin
      bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
      if (byte_tick_o) begin
        byte_cnt_d = last_byte_o ? '0 : byte_cnt_q + BYTE_IDX_W'(1);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

endmodule

// File: rtl/serial_frame_aligner.sv
// Frame aligner on an 8-bit serial shift-register window.
// Hunts for SYNC_BYTE in the whole window each clock, then locks and emits
// FRAME_LEN payload bytes sampled every 8th clock, then hunts again.
// Optional feature macro: FRAME_ALIGN_RESYNC_EN -- a sync pattern seen at
// a byte boundary while locked restarts the frame instead of being emitted.
// Ports:
//   Clk        clock, rising edge
//   Reset      synchronous active-high reset, highest priority
//   Window     shift window, Window[0] newest bit, bytes arrive MSB-first
//   Locked     high while in the locked state
//   ByteOut    last captured payload byte (held between captures)
//   ByteValid  one-cycle strobe per captured byte
//   ByteIdx    position of ByteOut within the frame
//   FrameDone  one-cycle strobe with the last byte of a frame
module serial_frame_aligner
  import frame_align_pkg::*;
#(
  parameter logic [BITS_PER_BYTE-1:0] SYNC_BYTE = DEFAULT_SYNC_BYTE,
  parameter int unsigned              FRAME_LEN = DEFAULT_FRAME_LEN  // 1..16
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [BITS_PER_BYTE-1:0] Window,
  output logic                     Locked,
  output logic [BITS_PER_BYTE-1:0] ByteOut,
  output logic                     ByteValid,
  output logic [BYTE_IDX_W-1:0]    ByteIdx,
  output logic                     FrameDone
);

  logic [0:0]            state_q, state_d;
  byte_beat_t            beat_q, beat_d;
  logic                  cnt_clr, cnt_en;
  logic [BYTE_IDX_W-1:0] byte_cnt;
  logic                  byte_tick, last_byte;
  logic                  sync_match;
  logic                  resync;

  frame_byte_counter #(
    .FRAME_LEN(FRAME_LEN)
  ) u_counter (
    .Clk        (Clk),
    .Reset      (Reset),
    .clr_i      (cnt_clr),
    .en_i       (cnt_en),
    .byte_cnt_o (byte_cnt),
    .byte_tick_o(byte_tick),
    .last_byte_o(last_byte)
  );

  assign sync_match = (Window == SYNC_BYTE);

  // Only consulted on a byte boundary while locked.
`ifdef FRAME_ALIGN_RESYNC_EN
  assign resync = sync_match;
`else
  assign resync = 1'b0;
`endif

  // Next-state and output-register logic; strobes default low every cycle.
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    beat_d.valid = 1'b0;
    beat_d.done  = 1'b0;
    cnt_clr      = 1'b0;
    cnt_en       = 1'b0;
    if (state_q == ST_HUNT) begin
      // Counters are held at zero so the match edge starts bit 0 of byte 0.
      cnt_clr = 1'b1;
      if (sync_match) begin
        state_d = ST_LOCKED;
      end
    end else begin
      cnt_en = 1'b1;
      if (byte_tick) begin
        if (resync) begin
          // Drop the partial frame and realign on this pattern.
          cnt_clr = 1'b1;
        end else begin
          beat_d.data  = Window;
          beat_d.idx   = byte_cnt;
          beat_d.valid = 1'b1;
          if (last_byte) begin
            beat_d.done = 1'b1;
            state_d     = ST_HUNT;
          end
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_HUNT;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  assign Locked    = (state_q == ST_LOCKED);
  assign ByteOut   = beat_q.data;
  assign ByteIdx   = beat_q.idx;
  assign ByteValid = beat_q.valid;
  assign FrameDone = beat_q.done;

endmodule

// File: tb/tb_serial_frame_aligner.sv
// Self-checking bench for serial_frame_aligner (SYNC_BYTE=A5, FRAME_LEN=4).
// The bench shifts a serial bit stream into Window one bit per clock and
// checks emitted bytes against a queue of expected {byte, idx, done, time}.
module tb_serial_frame_aligner;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] Window = 8'h00;
  logic       Locked;
  logic [7:0] ByteOut;
  logic       ByteValid;
  logic [3:0] ByteIdx;
  logic       FrameDone;

  int total = 0;
  int bad   = 0;
  int pos   = 0;
  int first_lock = -1;
  logic prev_locked = 1'b0;

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] idx;
    logic       done;
    int         at;
  } exp_t;

  exp_t sb[$];

  // Serial bytes (first byte leftmost), expected payload and sample times.
  typedef struct packed {
    logic [95:0] ser;
    int          nser;
    logic [63:0] exp;
    logic [63:0] epos;
    int          nexp;
    int          lock_pos;
  } vec_t;

  vec_t vec[4];

  serial_frame_aligner #(
    .SYNC_BYTE(8'hA5),
    .FRAME_LEN(4)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Window   (Window),
    .Locked   (Locked),
    .ByteOut  (ByteOut),
    .ByteValid(ByteValid),
    .ByteIdx  (ByteIdx),
    .FrameDone(FrameDone)
  );

  always #17 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (pos %0d)", name, act, req, pos);
    end
  endtask

  // Runs at the falling edge; outputs reflect the preceding rising edge.
  task automatic monitor();
    exp_t e;
    if (ByteValid === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_byte: got %02h idx %0d with nothing expected (pos %0d)",
                 ByteOut, ByteIdx, pos);
      end else begin
        e = sb.pop_front();
        check("byte_out",   32'(ByteOut),   32'(e.data));
        check("byte_idx",   32'(ByteIdx),   32'(e.idx));
        check("frame_done", 32'(FrameDone), 32'(e.done));
        check("byte_time",  32'(pos),       32'(e.at));
      end
    end else begin
      check("done_without_valid", 32'(FrameDone), 32'(0));
    end
    if (Locked === 1'b1 && first_lock < 0) first_lock = pos;
    if (prev_locked && Locked === 1'b0 && !Reset)
      check("locked_fall_with_done", 32'(FrameDone), 32'(1));
    prev_locked = Locked;
  endtask

  task automatic tick(input logic b, input logic rst);
    @(negedge Clk);
    monitor();
    Reset  = rst;
    Window = {Window[6:0], b};
    pos++;
  endtask

  task automatic run_entry(input vec_t v);
    logic [7:0] bt;
    exp_t e;
    pos = 0;
    first_lock = -1;
    check("idle_unlocked_before", 32'(Locked), 32'(0));
    for (int k = 0; k < v.nexp; k++) begin
      e.data = v.exp[63-8*k -: 8];
      e.idx  = 4'(k % 4);
      e.done = ((k % 4) == 3);
      e.at   = int'(v.epos[63-8*k -: 8]);
      sb.push_back(e);
    end
    for (int i = 0; i < v.nser; i++) begin
      bt = v.ser[95-8*i -: 8];
      for (int j = 7; j >= 0; j--) tick(bt[j], 1'b0);
    end
    repeat (24) tick(1'b0, 1'b0);
    check("lock_time",      32'(first_lock), 32'(v.lock_pos));
    check("queue_drained",  32'(sb.size()),  32'(0));
    check("unlocked_after", 32'(Locked),     32'(0));
    sb.delete();
  endtask

  initial begin
    logic [31:0] seq;
    exp_t e;

    vec[0] = '{ser: {8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 56'h0}, nser: 5,
               exp: {8'h11, 8'h22, 8'h33, 8'h44, 32'h0},
               epos: {8'd16, 8'd24, 8'd32, 8'd40, 32'h0}, nexp: 4, lock_pos: 8};
    vec[1] = '{ser: {8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'hA5, 8'h05, 8'h06, 8'h07, 8'h08, 16'h0},
               nser: 10,
               exp: {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08},
               epos: {8'd16, 8'd24, 8'd32, 8'd40, 8'd56, 8'd64, 8'd72, 8'd80},
               nexp: 8, lock_pos: 8};
`ifdef FRAME_ALIGN_RESYNC_EN
    vec[2] = '{ser: {8'hA5, 8'hA5, 8'h10, 8'h20, 8'h30, 56'h0}, nser: 5,
               exp: {8'h10, 8'h20, 8'h30, 8'h00, 32'h0},
               epos: {8'd24, 8'd32, 8'd40, 8'd48, 32'h0}, nexp: 4, lock_pos: 8};
`else
    vec[2] = '{ser: {8'hA5, 8'hA5, 8'h10, 8'h20, 8'h30, 56'h0}, nser: 5,
               exp: {8'hA5, 8'h10, 8'h20, 8'h30, 32'h0},
               epos: {8'd16, 8'd24, 8'd32, 8'd40, 32'h0}, nexp: 4, lock_pos: 8};
`endif
    // A4/25 never match; 0A,5B hides A5 four bits into 5B, so payload is nibble-shifted.
    vec[3] = '{ser: {8'hA4, 8'h25, 8'h0A, 8'h5B, 8'hC3, 8'h3C, 8'h99, 8'h00, 32'h0}, nser: 8,
               exp: {8'hBC, 8'h33, 8'hC9, 8'h90, 32'h0},
               epos: {8'd36, 8'd44, 8'd52, 8'd60, 32'h0}, nexp: 4, lock_pos: 28};

    // Reset for two clocks, then idle zeros must leave everything quiet.
    repeat (2) tick(1'b0, 1'b1);
    for (int c = 0; c < 20; c++) begin
      tick(1'b0, 1'b0);
      check("idle_locked",    32'(Locked),    32'(0));
      check("idle_valid",     32'(ByteValid), 32'(0));
      check("idle_byte_out",  32'(ByteOut),   32'(0));
    end

    for (int t = 0; t < 4; t++) run_entry(vec[t]);

    // Reset three clocks after the second payload byte aborts the frame.
    pos = 0;
    first_lock = -1;
    e = '{data: 8'h11, idx: 4'd0, done: 1'b0, at: 16};
    sb.push_back(e);
    e = '{data: 8'h22, idx: 4'd1, done: 1'b0, at: 24};
    sb.push_back(e);
    seq = {8'hA5, 8'h11, 8'h22, 8'h33};
    for (int n = 0; n < 27; n++) tick(seq[31-n], 1'b0);
    tick(seq[31-27], 1'b1);
    @(posedge Clk);
    #1;
    check("rst_locked",    32'(Locked),    32'(0));
    check("rst_valid",     32'(ByteValid), 32'(0));
    check("rst_byte_out",  32'(ByteOut),   32'(0));
    check("rst_byte_idx",  32'(ByteIdx),   32'(0));
    check("rst_done",      32'(FrameDone), 32'(0));
    for (int n = 28; n < 32; n++) tick(seq[31-n], 1'b0);
    repeat (24) tick(1'b0, 1'b0);
    check("rst_lock_time",  32'(first_lock), 32'(8));
    check("rst_queue_used", 32'(sb.size()),  32'(0));
    check("rst_unlocked",   32'(Locked),     32'(0));
    sb.delete();

    // Fresh frame after the aborted one.
    run_entry(vec[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
